// File: rtl/ddr_line_rd_req.sv
// Line fetch engine for the display path: turns line requests into AXI4 burst
// reads from one of two frame buffers and forwards returned beats to the line buffer.
module ddr_line_rd_req #(
  parameter int          DQ_WIDTH    = 32,
  parameter int          LINE_PIX    = 960,
  parameter int          V_LINES     = 720,
  parameter int          BURST_LEN   = 16,
  parameter logic [31:0] LINE_STRIDE = 32'h0000_1000,
  parameter logic [31:0] FRAME0_BASE = 32'h0000_0000,
  parameter logic [31:0] FRAME1_BASE = 32'h0040_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    frame_sel,
  input  logic                    line_req,
  output logic [31:0]             axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DQ_WIDTH*8-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready,
  output logic                    buf_wr_en,
  output logic [DQ_WIDTH*8-1:0]   buf_wr_data,
  output logic                    line_busy,
  output logic                    req_overflow
);

  localparam int          DW        = DQ_WIDTH * 8;
  localparam int          BEATS     = LINE_PIX * 16 / DW;
  localparam logic [15:0] BEATS_C   = 16'(BEATS);
  localparam logic [15:0] BURST_C   = 16'(BURST_LEN);
  localparam logic [10:0] V_LINES_C = 11'(V_LINES);
  localparam logic [31:0] BEAT_STEP = 32'(DQ_WIDTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t      state, state_next;
  logic [10:0] line_cnt;
  logic [31:0] frame_base;
  logic        pending;
  logic        drain_after_ar;
  logic [31:0] line_addr;
  logic [15:0] beats_left;
  logic [15:0] beats_sent;

  logic [31:0] base_eff;
  logic [10:0] cnt_eff;
  logic        pend_eff;
  logic        ovf_eff;
  logic        start;
  logic        ar_accept;
  logic        last_beat;
  logic        pending_next;
  logic        overflow_next;
  logic [31:0] start_addr;
  logic [15:0] burst_n;

  function automatic logic [7:0] burst_arlen(input logic [15:0] left);
    logic [15:0] n;
    n = (left > BURST_C) ? BURST_C : left;
    return 8'(n - 16'd1);
  endfunction

  assign axi_rready = 1'b1;
  assign line_busy  = (state != IDLE);

  // frame_start is applied before anything else seen in the same cycle
  always_comb begin
    base_eff      = frame_start ? (frame_sel ? FRAME1_BASE : FRAME0_BASE) : frame_base;
    cnt_eff       = frame_start ? 11'd0 : line_cnt;
    pend_eff      = frame_start ? 1'b0 : pending;
    ovf_eff       = frame_start ? 1'b0 : req_overflow;
    ar_accept     = axi_arvalid && axi_arready;
    last_beat     = axi_rvalid && axi_rlast;
    start_addr    = base_eff + ({21'd0, cnt_eff} * LINE_STRIDE);
    burst_n       = {8'd0, axi_arlen} + 16'd1;
    start         = 1'b0;
    state_next    = state;
    pending_next  = pend_eff;
    overflow_next = ovf_eff;
    case (state)
      IDLE: begin
        if (line_req || pend_eff) begin
          if (cnt_eff < V_LINES_C) begin
            start        = 1'b1;
            state_next   = ADDR;
            pending_next = line_req && pend_eff;
          end else begin
            pending_next = 1'b0;
          end
        end
      end
      ADDR: begin
        if (ar_accept)
          state_next = (drain_after_ar || frame_start) ? DRAIN : DATA;
      end
      DATA: begin
        if (last_beat)
          state_next = (frame_start || beats_left == 16'd0) ? IDLE : ADDR;
        else if (frame_start)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (last_beat)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && line_req) begin
      if (pend_eff)
        overflow_next = 1'b1;
      else
        pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_cnt       <= '0;
      frame_base     <= FRAME0_BASE;
      pending        <= 1'b0;
      req_overflow   <= 1'b0;
      drain_after_ar <= 1'b0;
      line_addr      <= '0;
      beats_left     <= '0;
      beats_sent     <= '0;
      axi_araddr     <= '0;
      axi_arlen      <= '0;
      axi_arvalid    <= 1'b0;
      buf_wr_en      <= 1'b0;
      buf_wr_data    <= '0;
    end else begin
      buf_wr_en    <= 1'b0;
      pending      <= pending_next;
      req_overflow <= overflow_next;
      if (frame_start) begin
        frame_base <= frame_sel ? FRAME1_BASE : FRAME0_BASE;
        line_cnt   <= '0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            line_addr      <= start_addr;
            beats_left     <= BEATS_C;
            beats_sent     <= '0;
            axi_araddr     <= start_addr;
            axi_arlen      <= burst_arlen(BEATS_C);
            axi_arvalid    <= 1'b1;
            drain_after_ar <= 1'b0;
          end
        end
        ADDR: begin
          // an accepted address always has a burst in flight that must be drained
          if (ar_accept) begin
            axi_arvalid    <= 1'b0;
            beats_left     <= beats_left - burst_n;
            beats_sent     <= beats_sent + burst_n;
            drain_after_ar <= 1'b0;
          end else if (frame_start) begin
            drain_after_ar <= 1'b1;
          end
        end
        DATA: begin
          if (axi_rvalid && !frame_start) begin
            buf_wr_en   <= 1'b1;
            buf_wr_data <= axi_rdata;
          end
          if (last_beat && !frame_start) begin
            if (beats_left != 16'd0) begin
              axi_arvalid <= 1'b1;
              axi_araddr  <= line_addr + ({16'd0, beats_sent} * BEAT_STEP);
              axi_arlen   <= burst_arlen(beats_left);
            end else begin
              line_cnt <= line_cnt + 11'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_line_rd_req.sv
// Directed bench for ddr_line_rd_req: a simple AXI read slave plus hand-computed
// address, write-count and flag expectations.
module tb_ddr_line_rd_req;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          frame_sel;
  logic          line_req;
  logic [31:0]   axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rvalid;
  logic          axi_rlast;
  logic          axi_rready;
  logic          buf_wr_en;
  logic [DW-1:0] buf_wr_data;
  logic          line_busy;
  logic          req_overflow;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  int          rd_left    = 0;
  int          rd_next    = 0;
  int          rv_stall   = 0;
  int          ar_stall   = 0;
  int unsigned beat_serial = 0;
  int          wr_count   = 0;

  always #5 clk = ~clk;

  ddr_line_rd_req dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_sel    (frame_sel),
    .line_req     (line_req),
    .axi_araddr   (axi_araddr),
    .axi_arlen    (axi_arlen),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rvalid   (axi_rvalid),
    .axi_rlast    (axi_rlast),
    .axi_rready   (axi_rready),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_data  (buf_wr_data),
    .line_busy    (line_busy),
    .req_overflow (req_overflow)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: pulse inputs, observe writes, then play the AXI slave for the next edge
  task automatic applyStimulus(input logic fs, input logic lreq);
    frame_start = fs;
    line_req    = lreq;
    @(negedge clk);
    frame_start = 1'b0;
    line_req    = 1'b0;
    if (buf_wr_en) begin
      wr_count++;
      checkOutput("wr_latency", 256'(axi_rvalid), 256'(1));
      checkOutput("wr_data", buf_wr_data, axi_rdata);
    end
    if (rd_next != 0) begin
      rd_left = rd_next;
      rd_next = 0;
    end
    if (rv_stall > 0) begin
      rv_stall--;
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
    end else if (rd_left > 0) begin
      axi_rvalid = 1'b1;
      axi_rdata  = {8{beat_serial ^ 32'hA5A5_0000}};
      axi_rlast  = (rd_left == 1);
      rd_left--;
      beat_serial++;
    end else begin
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
    end
    if (axi_arvalid && ar_stall > 0) begin
      axi_arready = 1'b0;
      ar_stall--;
    end else begin
      axi_arready = 1'b1;
    end
    if (axi_arvalid && axi_arready) begin
      ar_addr_q.push_back(axi_araddr);
      ar_len_q.push_back(axi_arlen);
      rd_next = int'(axi_arlen) + 1;
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      applyStimulus(1'b0, 1'b0);
      n++;
      quiet = (!line_busy && rd_left == 0 && rd_next == 0) ? quiet + 1 : 0;
    end
    checkOutput(tag, 256'(quiet >= 3), 256'(1));
  endtask

  task automatic waitWrites(input string tag, input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput(tag, 256'(wr_count), 256'(target));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_arvalid"}, 256'(axi_arvalid), 256'(0));
    checkOutput({tag, "_araddr"}, 256'(axi_araddr), 256'(0));
    checkOutput({tag, "_arlen"}, 256'(axi_arlen), 256'(0));
    checkOutput({tag, "_wr_en"}, 256'(buf_wr_en), 256'(0));
    checkOutput({tag, "_wr_data"}, buf_wr_data, 256'(0));
    checkOutput({tag, "_busy"}, 256'(line_busy), 256'(0));
    checkOutput({tag, "_ovf"}, 256'(req_overflow), 256'(0));
    checkOutput({tag, "_rready"}, 256'(axi_rready), 256'(1));
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_addr [4];
    logic [7:0]  exp_len  [4];
    exp_addr = '{32'h000, 32'h200, 32'h400, 32'h600};
    exp_len  = '{8'd15, 8'd15, 8'd15, 8'd11};

    rst = 1'b0; frame_start = 1'b0; frame_sel = 1'b0; line_req = 1'b0;
    axi_arready = 1'b1; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkReset("rst");
    rst = 1'b1;

    // Test 1: one full line from frame 0
    $display("[TB] test 1: single line");
    frame_sel = 1'b0;
    applyStimulus(1'b1, 1'b0);
    ar_addr_q.delete(); ar_len_q.delete(); wr_count = 0;
    applyStimulus(1'b0, 1'b1);
    waitWrites("t1_w59", 59, 200);
    checkOutput("t1_busy_before_last", 256'(line_busy), 256'(1));
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_last_write", 256'(wr_count), 256'(60));
    checkOutput("t1_busy_fall", 256'(line_busy), 256'(0));
    waitIdle("t1_idle", 50);
    checkOutput("t1_ar_count", 256'(ar_addr_q.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_ar%0d_addr", i), 256'(ar_addr_q[i]), 256'(exp_addr[i]));
      checkOutput($sformatf("t1_ar%0d_len", i), 256'(ar_len_q[i]), 256'(exp_len[i]));
    end
    applyStimulus(1'b0, 1'b1);
    waitIdle("t1_idle2", 200);
    checkOutput("t1_line1_addr", 256'(ar_addr_q[4]), 256'(32'h0000_1000));
    checkOutput("t1_wr_total", 256'(wr_count), 256'(120));

    // Test 2: frame 1, three lines
    $display("[TB] test 2: frame 1 base");
    frame_sel = 1'b1;
    applyStimulus(1'b1, 1'b0);
    ar_addr_q.delete(); ar_len_q.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      waitIdle("t2_idle", 200);
    end
    checkOutput("t2_ar_count", 256'(ar_addr_q.size()), 256'(12));
    checkOutput("t2_l0_addr", 256'(ar_addr_q[0]), 256'(32'h0040_0000));
    checkOutput("t2_l1_addr", 256'(ar_addr_q[4]), 256'(32'h0040_1000));
    checkOutput("t2_l2_addr", 256'(ar_addr_q[8]), 256'(32'h0040_2000));
    checkOutput("t2_l2_tail_addr", 256'(ar_addr_q[11]), 256'(32'h0040_2600));
    checkOutput("t2_l2_tail_len", 256'(ar_len_q[11]), 256'(11));

    // Test 3: queued request and overflow
    $display("[TB] test 3: pending and overflow");
    applyStimulus(1'b1, 1'b0);
    ar_addr_q.delete(); ar_len_q.delete(); wr_count = 0;
    applyStimulus(1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3_ovf_after_queue", 256'(req_overflow), 256'(0));
    repeat (5) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3_ovf_set", 256'(req_overflow), 256'(1));
    waitIdle("t3_idle", 300);
    checkOutput("t3_ar_count", 256'(ar_addr_q.size()), 256'(8));
    checkOutput("t3_l1_addr", 256'(ar_addr_q[4]), 256'(32'h0040_1000));
    checkOutput("t3_wr_total", 256'(wr_count), 256'(120));
    checkOutput("t3_ovf_sticky", 256'(req_overflow), 256'(1));
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_ovf_cleared", 256'(req_overflow), 256'(0));

    // Test 4: frame_start in the third burst, drain, then queued line at new base
    $display("[TB] test 4: drain");
    frame_sel = 1'b0;
    applyStimulus(1'b1, 1'b0);
    ar_addr_q.delete(); ar_len_q.delete(); wr_count = 0;
    applyStimulus(1'b0, 1'b1);
    waitWrites("t4_w35", 35, 200);
    rv_stall = 1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_w36", 256'(wr_count), 256'(36));
    frame_sel = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_busy_drain", 256'(line_busy), 256'(1));
    checkOutput("t4_ar_before", 256'(ar_addr_q.size()), 256'(3));
    repeat (2) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitIdle("t4_idle", 300);
    checkOutput("t4_ar_count", 256'(ar_addr_q.size()), 256'(7));
    checkOutput("t4_new_addr", 256'(ar_addr_q[3]), 256'(32'h0040_0000));
    checkOutput("t4_new_len", 256'(ar_len_q[3]), 256'(15));
    checkOutput("t4_new_tail", 256'(ar_addr_q[6]), 256'(32'h0040_0600));
    checkOutput("t4_wr_total", 256'(wr_count), 256'(96));
    checkOutput("t4_ovf", 256'(req_overflow), 256'(0));

    // Test 5: arready withheld for 10 cycles
    $display("[TB] test 5: arready stall");
    ar_stall = 10;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t5_hold%0d", i),
                  256'({axi_arvalid, axi_araddr, axi_arlen, buf_wr_en}),
                  256'({1'b1, 32'h0040_1000, 8'd15, 1'b0}));
      applyStimulus(1'b0, 1'b0);
    end
    waitIdle("t5_idle", 200);
    checkOutput("t5_ar_count", 256'(ar_addr_q.size()), 256'(11));
    checkOutput("t5_ar_addr", 256'(ar_addr_q[7]), 256'(32'h0040_1000));

    // Test 6: full frame, extra request, reset mid-burst
    $display("[TB] test 6: full frame and reset");
    frame_sel = 1'b0;
    applyStimulus(1'b1, 1'b0);
    ar_addr_q.delete(); ar_len_q.delete(); wr_count = 0;
    for (int i = 0; i < 720; i++) begin
      applyStimulus(1'b0, 1'b1);
      waitIdle("t6_line_idle", 200);
    end
    checkOutput("t6_ar_count", 256'(ar_addr_q.size()), 256'(2880));
    checkOutput("t6_l1_addr", 256'(ar_addr_q[4]), 256'(32'h0000_1000));
    checkOutput("t6_last_addr", 256'(ar_addr_q[2879]), 256'(32'h002C_F600));
    checkOutput("t6_last_len", 256'(ar_len_q[2879]), 256'(11));
    checkOutput("t6_wr_total", 256'(wr_count), 256'(43200));
    applyStimulus(1'b0, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("t6_extra_no_ar", 256'(ar_addr_q.size()), 256'(2880));
    checkOutput("t6_extra_busy", 256'(line_busy), 256'(0));
    checkOutput("t6_extra_ovf", 256'(req_overflow), 256'(0));

    frame_sel = 1'b1;
    applyStimulus(1'b1, 1'b0);
    ar_addr_q.delete(); ar_len_q.delete(); wr_count = 0;
    applyStimulus(1'b0, 1'b1);
    waitWrites("t6_w20", 20, 100);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t6_pre_rst_ovf", 256'(req_overflow), 256'(1));
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkReset("t6_rst");
    rst = 1'b1;
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("t6_rst_wr_frozen", 256'(wr_count), 256'(22));
    checkOutput("t6_rst_ar_count", 256'(ar_addr_q.size()), 256'(2));
    checkOutput("t6_rst_busy", 256'(line_busy), 256'(0));
    applyStimulus(1'b0, 1'b1);
    waitIdle("t6_post_rst_idle", 200);
    checkOutput("t6_post_rst_addr", 256'(ar_addr_q[2]), 256'(32'h0000_0000));
    checkOutput("t6_post_rst_wr", 256'(wr_count), 256'(82));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
